mips_harvard_test_monitor: RTL and testbench



---
 rtl/mips_tb_pkg.sv | 19 +
 rtl/mips_tb_rom.sv | 39 +++
 rtl/mips_harvard_test_monitor.sv | 131 +++++++++++++
 tb/tb_mips_harvard_test_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the mips_cpu_harvard test monitor.
// Holds the run-state encoding, reset vector, NOP word and byte-lane swap helper.
package mips_tb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT,
        TIMEOUT
    } state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mips_tb_rom.sv
// Program ROM for the test monitor: synchronous write port, combinational fetch port.
// Fetches that are misaligned or outside the ROM window return NOP and drop in_range.
module mips_tb_rom
    import mips_tb_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter logic [31:0] BASE_ADDR  = RESET_VECTOR,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [31:0]              raddr,
    output logic [31:0]              rdata,
    output logic                     in_range
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [31:0] offset;
    logic [31:0] word;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Word index is the offset from the reset vector; any upper offset bit set means past the end.
    always_comb begin
        offset   = raddr - BASE_ADDR;
        in_range = (offset[1:0] == 2'b00) && (offset[31:AW+2] == '0);
        word     = in_range ? mem[offset[AW+1:2]] : NOP;
        rdata    = SWAP_BYTES ? byte_swap(word) : word;
    end

endmodule

// File: rtl/mips_harvard_test_monitor.sv
// Program ROM plus run monitor for mips_cpu_harvard harnesses: sequences CPU reset,
// counts run cycles, detects halt (fetch of address 0 while inactive) or timeout.
module mips_harvard_test_monitor
    import mips_tb_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter logic [31:0] BASE_ADDR  = RESET_VECTOR,
    parameter bit          SWAP_BYTES = 1'b1,
    parameter int unsigned MAX_CYCLES = 1000,
    parameter int unsigned CW         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic                     start,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    output logic                     cpu_reset,
    input  logic [31:0]              instr_address,
    output logic [31:0]              instr_readdata,
    input  logic                     active,
    input  logic [31:0]              register_v0,
    input  logic [31:0]              expected_v0,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic                     oob_fetch,
    output logic [31:0]              result_v0,
    output logic [CW-1:0]            cycle_count
);

    if (CW < $clog2(MAX_CYCLES)) begin : g_cw_check
        $error("cycle_count width CW is too narrow for MAX_CYCLES");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 4");
    end

    localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);

    state_t state;
    state_t state_next;
    logic   in_range;
    logic   halt_det;
    logic   last_cycle;
    logic   fetch_oob;

    mips_tb_rom #(
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE_ADDR),
        .SWAP_BYTES (SWAP_BYTES)
    ) u_rom (
        .clk      (clk),
        .we       (load_we && (state != RUN)),
        .waddr    (load_addr),
        .wdata    (load_data),
        .raddr    (instr_address),
        .rdata    (instr_readdata),
        .in_range (in_range)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The first RUN cycle is excluded from halt detection while the CPU leaves reset.
    always_comb begin
        halt_det   = !active && (instr_address == '0) && (cycle_count != '0);
        last_cycle = (cycle_count == LAST_CYCLE);
        fetch_oob  = !in_range && (instr_address != '0);
        cpu_reset  = (state != RUN);
        state_next = state;
        if (clk_enable) begin
            case (state)
                IDLE, HALT, TIMEOUT: if (start) state_next = RUN;
                RUN: begin
                    if (halt_det) begin
                        state_next = HALT;
                    end else if (last_cycle) begin
                        state_next = TIMEOUT;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            oob_fetch   <= 1'b0;
            result_v0   <= '0;
            cycle_count <= '0;
        end else if (clk_enable) begin
            if (state != RUN) begin
                if (start) begin
                    done        <= 1'b0;
                    pass        <= 1'b0;
                    timeout     <= 1'b0;
                    oob_fetch   <= 1'b0;
                    result_v0   <= '0;
                    cycle_count <= '0;
                end
            end else begin
                if (fetch_oob) begin
                    oob_fetch <= 1'b1;
                end
                // Count advances only while staying in RUN, so it freezes at the exit cycle.
                if (halt_det) begin
                    result_v0 <= register_v0;
                    pass      <= (register_v0 == expected_v0);
                    done      <= 1'b1;
                end else if (last_cycle) begin
                    timeout <= 1'b1;
                    done    <= 1'b1;
                    pass    <= 1'b0;
                end else if (cycle_count != '1) begin
                    cycle_count <= cycle_count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_harvard_test_monitor.sv
// Self-checking bench for mips_harvard_test_monitor with a tiny MIPS fetch/execute model.
// Run results go through a scoreboard queue; ROM reads use a vector table.
module tb_mips_harvard_test_monitor;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int unsigned MAXC  = 50;
    localparam int unsigned CW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic          start;
    logic          load_we;
    logic [5:0]    load_addr;
    logic [31:0]   load_data;
    logic          cpu_reset;
    logic [31:0]   instr_address;
    logic [31:0]   instr_readdata;
    logic          active;
    logic [31:0]   register_v0;
    logic [31:0]   expected_v0;
    logic          done;
    logic          pass;
    logic          timeout;
    logic          oob_fetch;
    logic [31:0]   result_v0;
    logic [CW-1:0] cycle_count;

    logic          use_model;
    logic [31:0]   drv_addr;
    logic          drv_active;
    logic [31:0]   drv_v0;

    logic [31:0]   m_pc;
    logic [31:0]   m_npc;
    logic          m_active;
    logic [31:0]   m_regs [32];
    logic [31:0]   m_ins;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [31:0] result;
        logic [15:0] count;
        logic        oob;
    } run_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
    } rd_vec_t;

    run_exp_t sb[$];
    rd_vec_t  vecs[8];

    always #5 clk = ~clk;

    assign instr_address = use_model ? m_pc : drv_addr;
    assign active        = use_model ? m_active : drv_active;
    assign register_v0   = use_model ? m_regs[2] : drv_v0;

    mips_harvard_test_monitor #(
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE),
        .SWAP_BYTES (1'b1),
        .MAX_CYCLES (MAXC),
        .CW         (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .start          (start),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .cpu_reset      (cpu_reset),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .active         (active),
        .register_v0    (register_v0),
        .expected_v0    (expected_v0),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .oob_fetch      (oob_fetch),
        .result_v0      (result_v0),
        .cycle_count    (cycle_count)
    );

    // CPU model with branch delay slot; goes inactive when the PC reaches 0.
    always_comb m_ins = {instr_readdata[7:0], instr_readdata[15:8],
                         instr_readdata[23:16], instr_readdata[31:24]};

    always @(posedge clk) begin
        if (cpu_reset) begin
            m_pc     <= BASE;
            m_npc    <= BASE + 32'd4;
            m_active <= 1'b1;
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
        end else if (clk_enable && m_active) begin
            m_pc     <= m_npc;
            m_active <= (m_npc != 32'd0);
            m_npc    <= m_npc + 32'd4;
            case (m_ins[31:26])
                6'h09: if (m_ins[20:16] != 5'd0)
                    m_regs[m_ins[20:16]] <= m_regs[m_ins[25:21]] + {{16{m_ins[15]}}, m_ins[15:0]};
                6'h04: if (m_regs[m_ins[25:21]] == m_regs[m_ins[20:16]])
                    m_npc <= m_pc + 32'd4 + {{14{m_ins[15]}}, m_ins[15:0], 2'b00};
                6'h00: if (m_ins[5:0] == 6'h08)
                    m_npc <= m_regs[m_ins[25:21]];
                default: ;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input int unsigned a, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = 6'(a);
        load_data = d;
        tick;
        load_we   = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic start_run(input run_exp_t e);
        sb.push_back(e);
        pulse_start;
    endtask

    task automatic wait_done(input int budget, input string tag);
        run_exp_t e;
        int n = 0;
        while (!done && n < budget) begin
            tick;
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        e = sb.pop_front();
        check({tag, "_pass"},    32'(pass),        32'(e.pass));
        check({tag, "_timeout"}, 32'(timeout),     32'(e.timeout));
        check({tag, "_result"},  result_v0,        e.result);
        check({tag, "_count"},   32'(cycle_count), 32'(e.count));
        check({tag, "_oob"},     32'(oob_fetch),   32'(e.oob));
        check({tag, "_cpu_rst"}, 32'(cpu_reset),   32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{BASE,                 32'h05000224};
        vecs[1] = '{BASE + 32'd4,         32'h08000000};
        vecs[2] = '{BASE + 32'd2,         32'h00000000};
        vecs[3] = '{BASE + 32'd1,         32'h00000000};
        vecs[4] = '{BASE + 32'd252,       32'h78563412};
        vecs[5] = '{BASE + 32'd256,       32'h00000000};
        vecs[6] = '{BASE - 32'd4,         32'h00000000};
        vecs[7] = '{32'h00000000,         32'h00000000};

        reset = 1'b1; clk_enable = 1'b1; start = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        expected_v0 = 32'd5;
        use_model = 1'b0; drv_addr = BASE; drv_active = 1'b1; drv_v0 = '0;
        repeat (3) tick;
        reset = 1'b0;

        check("rst_cpu_reset", 32'(cpu_reset),   32'd1);
        check("rst_done",      32'(done),        32'd0);
        check("rst_pass",      32'(pass),        32'd0);
        check("rst_timeout",   32'(timeout),     32'd0);
        check("rst_oob",       32'(oob_fetch),   32'd0);
        check("rst_result",    result_v0,        32'd0);
        check("rst_count",     32'(cycle_count), 32'd0);

        load_word(0, 32'h24020005);
        load_word(1, 32'h00000008);
        load_word(2, 32'h00000000);
        load_word(63, 32'h12345678);

        for (int i = 0; i < 8; i++) begin
            drv_addr = vecs[i].addr;
            #1;
            check($sformatf("rom_rd%0d", i), instr_readdata, vecs[i].rdata);
        end
        tick;
        check("idle_no_oob", 32'(oob_fetch), 32'd0);

        use_model = 1'b1;
        expected_v0 = 32'd5;
        start_run('{1'b1, 1'b0, 32'd5, 16'd3, 1'b0});
        wait_done(40, "run_pass");

        expected_v0 = 32'd6;
        start_run('{1'b0, 1'b0, 32'd5, 16'd3, 1'b0});
        wait_done(40, "run_fail");

        use_model = 1'b0; drv_addr = BASE; drv_active = 1'b1;
        pulse_start;
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        tick;
        check("oob_inrange", 32'(oob_fetch), 32'd0);
        drv_addr = 32'd0;
        tick;
        check("oob_addr0", 32'(oob_fetch), 32'd0);
        drv_addr = BASE + 32'd2;
        #1;
        check("misalign_nop", instr_readdata, 32'd0);
        tick;
        check("oob_misalign", 32'(oob_fetch), 32'd1);
        drv_addr = BASE;
        tick;
        check("oob_sticky", 32'(oob_fetch), 32'd1);
        check("oob_no_done", 32'(done), 32'd0);

        reset = 1'b1; tick; reset = 1'b0;
        check("oob_rst_clear", 32'(oob_fetch), 32'd0);
        pulse_start;
        drv_addr = BASE + 32'd256;
        tick;
        check("oob_past_end", 32'(oob_fetch), 32'd1);
        load_word(1, 32'hFFFFFFFF);
        drv_addr = BASE + 32'd4;
        #1;
        check("rom_we_in_run", instr_readdata, 32'h08000000);

        reset = 1'b1; tick; reset = 1'b0;
        drv_addr = BASE;
        pulse_start;
        repeat (10) tick;
        check("mid_count10", 32'(cycle_count), 32'd10);
        reset = 1'b1;
        tick;
        check("mid_cpu_reset", 32'(cpu_reset),   32'd1);
        check("mid_count",     32'(cycle_count), 32'd0);
        check("mid_done",      32'(done),        32'd0);
        reset = 1'b0;
        use_model = 1'b1;
        expected_v0 = 32'd5;
        start_run('{1'b1, 1'b0, 32'd5, 16'd3, 1'b0});
        wait_done(40, "rerun");

        use_model = 1'b0; drv_addr = BASE; drv_active = 1'b1; drv_v0 = 32'd5;
        pulse_start;
        repeat (4) tick;
        clk_enable = 1'b0;
        drv_addr = 32'd0; drv_active = 1'b0;
        repeat (5) tick;
        check("ce_count_frozen", 32'(cycle_count), 32'd4);
        check("ce_no_done",      32'(done),        32'd0);
        check("ce_still_run",    32'(cpu_reset),   32'd0);
        sb.push_back('{1'b1, 1'b0, 32'd5, 16'd4, 1'b0});
        clk_enable = 1'b1;
        wait_done(5, "ce_halt");

        load_word(0, 32'h1000FFFF);
        load_word(1, 32'h00000000);
        use_model = 1'b1;
        start_run('{1'b0, 1'b1, 32'd0, 16'd49, 1'b0});
        wait_done(100, "timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
